reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Shares the register file's single write port between two writeback requesters: port A (ALU result path) and port B (load/memory return path). Each port has a one-entry holding slot with a valid/ready handshake. A registered arbiter drains one slot per cycle into the register file using a one-hot write enable and a data bus. The arbiter uses round-robin selection with age ordering for same-register conflicts, and exports a per-register pending mask for the decode stage's hazard checks.

## Interface
- DW, 16, data width of register values
- NREG, 16, number of architectural registers (one-hot enable width)
- AW, 4, register address width (log2 NREG)

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  port A has a write request
- a_addr  in  AW  port A destination register
- a_data  in  DW  port A write value
- a_ready  out  1  port A slot can accept this cycle
- b_valid  in  1  port B has a write request
- b_addr  in  AW  port B destination register
- b_data  in  DW  port B write value
- b_ready  out  1  port B slot can accept this cycle
- wr_en  out  NREG  one-hot write enable to register file (all-zero = no write)
- wr_data  out  DW  write value to register file
- pend  out  NREG  bit i set while any held slot targets register i

## Operation
- State: slot_a {full, addr, data}, slot_b {full, addr, data}, last_grant (A/B), a_older (1 = slot A was accepted before slot B).
- Accept: on an edge where x_valid & x_ready, slot_x loads addr/data and full <= 1.
- x_ready = !slot_x.full | grant_x. A slot being drained this cycle can refill on the same edge.
- Grant is combinational from registered state only, with no input-to-output path:
  - Only one slot full: grant it.
  - Both full, addresses differ: grant the port != last_grant.
  - Both full, same address: grant the older slot (a_older). Round-robin is bypassed, so the final register value is always the later request.
  - Neither full: no grant, wr_en = 0.
- Output: wr_en = one-hot(addr of granted slot), wr_data = data of granted slot. The register file commits on the same edge, and the granted slot's full <= 0 unless refilled on that edge.
- last_grant updates only on edges with a grant.
- Age tracking:
  - Accept into A while B stays full and is not drained: a_older <= 0.
  - Accept into B while A stays full and is not drained: a_older <= 1.
  - Simultaneous accept into both: a_older <= 1 (A defined older).
  - Otherwise a_older holds.
- pend = (slot_a.full ? onehot(slot_a.addr) : 0) | (slot_b.full ? onehot(slot_b.addr) : 0).
- A held request is never dropped or reordered against a same-address request.

## Timing
- Reset (asynchronous, immediate):
  - slots empty
  - a_ready = b_ready = 1
  - wr_en = 0
  - wr_data = 0
  - pend = 0
  - last_grant = B, so A wins the first tie
  - a_older = 1
- Latency: accepted at edge N, wr_en asserted during cycle N to N+1, register written at edge N+1.
- Throughput: 1 write/cycle total. A lone port sustains 1/cycle via drain-and-refill. Two always-valid ports alternate, each at 1 per 2 cycles.
- Back-to-back requests to the same register from one port are written in arrival order.
- Reset asserted mid-operation discards held slots; no write occurs after reset assertion.
- Reset deassertion is synchronous to clk externally; the block needs no extra cycle before accepting.

## Test plan
- Reset then idle: after rst, a_ready=b_ready=1, wr_en=0, pend=0. Drive a_valid with a_addr=3, a_data=0x0123 for one cycle. Next cycle: wr_en=0x0008, wr_data=0x0123, pend=0x0008. Following cycle: wr_en=0, pend=0.
- Single-port streaming: A sends addr 1..4 with data 0x1111..0x4444 on consecutive cycles. a_ready stays 1, and wr_en walks 0x0002, 0x0004, 0x0008, 0x0010 on consecutive cycles one cycle behind the inputs.
- Round-robin: both ports always valid, A addr 5, B addr 7, with distinct data. Grants alternate A, B, A, B, and a_ready/b_ready each toggle low every other cycle.
- Same-address ordering: A writes addr 2 = 0xAAAA at edge N while B is blocked behind a prior B grant. B writes addr 2 = 0xBBBB at edge N+1. The register-file write sequence is 0xAAAA then 0xBBBB regardless of last_grant. Repeat with B first: 0xBBBB then 0xAAAA.
- Simultaneous same-address accept: both valid in the same cycle, addr 15, A=0x1234, B=0xAEAE. A is written first, B second, leaving final value 0xAEAE. pend[15] stays 1 across both write cycles.
- Reset mid-operation: both slots full, rst pulsed between edges. wr_en and pend drop to 0 immediately, no write follows, and both readies are 1 after release.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Two-port writeback arbiter for a single register-file write port.
// Each port owns a one-entry slot; one slot drains per cycle, round-robin, oldest-first on same register.
module reg_write_arbiter #(
    parameter int DW   = 16,
    parameter int NREG = 16,
    parameter int AW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_data,
    output logic            b_ready,
    output logic [NREG-1:0] wr_en,
    output logic [DW-1:0]   wr_data,
    output logic [NREG-1:0] pend
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic          full;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } slot_t;

    slot_t slot_a;
    slot_t slot_b;
    port_e last_grant;
    logic  a_older;

    logic grant_a;
    logic grant_b;
    logic accept_a;
    logic accept_b;
    logic both_full;
    logic same_addr;

    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Grant depends on registered state only; a same-register conflict overrides round-robin.
    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        both_full = slot_a.full & slot_b.full;
        same_addr = (slot_a.addr == slot_b.addr);
        if (both_full) begin
            if (same_addr) begin
                grant_a = a_older;
                grant_b = !a_older;
            end else begin
                grant_a = (last_grant == PORT_B);
                grant_b = (last_grant == PORT_A);
            end
        end else begin
            grant_a = slot_a.full;
            grant_b = slot_b.full;
        end
    end

    assign a_ready  = !slot_a.full | grant_a;
    assign b_ready  = !slot_b.full | grant_b;
    assign accept_a = a_valid & a_ready;
    assign accept_b = b_valid & b_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_a <= '0;
        end else if (accept_a) begin
            slot_a.full <= 1'b1;
            slot_a.addr <= a_addr;
            slot_a.data <= a_data;
        end else if (grant_a) begin
            slot_a.full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_b <= '0;
        end else if (accept_b) begin
            slot_b.full <= 1'b1;
            slot_b.addr <= b_addr;
            slot_b.data <= b_data;
        end else if (grant_b) begin
            slot_b.full <= 1'b0;
        end
    end

    // Starting from B makes A win the first different-register tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT_B;
        end else if (grant_a) begin
            last_grant <= PORT_A;
        end else if (grant_b) begin
            last_grant <= PORT_B;
        end
    end

    // Age only matters while the other slot stays occupied; a simultaneous pair counts A as older.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_older <= 1'b1;
        end else if (accept_a && accept_b) begin
            a_older <= 1'b1;
        end else if (accept_a && slot_b.full && !grant_b) begin
            a_older <= 1'b0;
        end else if (accept_b && slot_a.full && !grant_a) begin
            a_older <= 1'b1;
        end
    end

    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        if (grant_a) begin
            wr_en   = onehot(slot_a.addr);
            wr_data = slot_a.data;
        end else if (grant_b) begin
            wr_en   = onehot(slot_b.addr);
            wr_data = slot_b.data;
        end
    end

    always_comb begin
        pend = '0;
        if (slot_a.full) begin
            pend = pend | onehot(slot_a.addr);
        end
        if (slot_b.full) begin
            pend = pend | onehot(slot_b.addr);
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench: accepted requests queue up in arrival order and the monitor
// predicts each write-port cycle from that queue and the last port served.
module tb_reg_write_arbiter;

    localparam int DW   = 16;
    localparam int NREG = 16;
    localparam int AW   = 4;

    logic            clk;
    logic            rst;
    logic            a_valid;
    logic [AW-1:0]   a_addr;
    logic [DW-1:0]   a_data;
    logic            a_ready;
    logic            b_valid;
    logic [AW-1:0]   b_addr;
    logic [DW-1:0]   b_data;
    logic            b_ready;
    logic [NREG-1:0] wr_en;
    logic [DW-1:0]   wr_data;
    logic [NREG-1:0] pend;

    typedef struct {
        bit            port;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    req_t q[$];
    bit   last_port;
    bit   drain_check;
    int   tests;
    int   fails;

    reg_write_arbiter #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
        .clk(clk),
        .rst(rst),
        .a_valid(a_valid),
        .a_addr(a_addr),
        .a_data(a_data),
        .a_ready(a_ready),
        .b_valid(b_valid),
        .b_addr(b_addr),
        .b_data(b_data),
        .b_ready(b_ready),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .pend(pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Held requests: at most one per port; queue order is arrival order.
    task automatic checkOutput();
        int              ia;
        int              ib;
        int              sel;
        logic [NREG-1:0] exp_pend;
        logic [NREG-1:0] exp_en;
        logic [DW-1:0]   exp_data;
        ia       = -1;
        ib       = -1;
        sel      = -1;
        exp_pend = '0;
        exp_en   = '0;
        exp_data = '0;
        foreach (q[i]) begin
            if (q[i].port == 1'b0) ia = i;
            else ib = i;
            exp_pend[q[i].addr] = 1'b1;
        end
        if (ia >= 0 && ib >= 0) begin
            if (q[ia].addr == q[ib].addr) sel = 0;
            else sel = last_port ? ia : ib;
        end else if (ia >= 0) begin
            sel = ia;
        end else if (ib >= 0) begin
            sel = ib;
        end
        if (sel >= 0) begin
            exp_en[q[sel].addr] = 1'b1;
            exp_data            = q[sel].data;
        end
        compare("pend", 32'(pend), 32'(exp_pend));
        compare("wr_en", 32'(wr_en), 32'(exp_en));
        compare("wr_data", 32'(wr_data), 32'(exp_data));
        compare("a_ready", 32'(a_ready), 32'((ia < 0) || (sel == ia)));
        compare("b_ready", 32'(b_ready), 32'((ib < 0) || (sel == ib)));
        if (sel >= 0) begin
            last_port = q[sel].port;
            q.delete(sel);
        end
    endtask

    always begin
        @(negedge clk or posedge rst);
        if (rst) begin
            #1;
            q.delete();
            last_port = 1'b1;
            compare("rst_wr_en", 32'(wr_en), 32'd0);
            compare("rst_wr_data", 32'(wr_data), 32'd0);
            compare("rst_pend", 32'(pend), 32'd0);
            compare("rst_a_ready", 32'(a_ready), 32'd1);
            compare("rst_b_ready", 32'(b_ready), 32'd1);
        end else begin
            if (drain_check) compare("drained", 32'(q.size()), 32'd0);
            checkOutput();
        end
    end

    task automatic applyStimulus(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                 input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        @(negedge clk);
        #2;
        a_valid = av;
        a_addr  = aa;
        a_data  = ad;
        b_valid = bv;
        b_addr  = ba;
        b_data  = bd;
        if (av && a_ready) q.push_back('{1'b0, aa, ad});
        if (bv && b_ready) q.push_back('{1'b1, ba, bd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic resetPulse();
        @(negedge clk);
        #3;
        rst     = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        tests       = 0;
        fails       = 0;
        drain_check = 1'b0;
        last_port   = 1'b1;
        rst         = 1'b1;
        a_valid     = 1'b0;
        b_valid     = 1'b0;
        a_addr      = '0;
        b_addr      = '0;
        a_data      = '0;
        b_data      = '0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;

        applyStimulus(1'b1, 4'd3, 16'h0123, 1'b0, '0, '0);
        idle(2);

        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b1, AW'(i), DW'(i * 16'h1111), 1'b0, '0, '0);
        idle(2);

        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 4'd5, DW'($urandom), 1'b1, 4'd7, DW'($urandom));
        idle(3);

        applyStimulus(1'b1, 4'd4, 16'h0404, 1'b1, 4'd9, 16'h0909);
        applyStimulus(1'b1, 4'd2, 16'hAAAA, 1'b1, 4'd9, 16'h9999);
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd2, 16'hBBBB);
        idle(3);
        applyStimulus(1'b1, 4'd9, 16'h0909, 1'b1, 4'd4, 16'h0404);
        applyStimulus(1'b1, 4'd9, 16'h9999, 1'b1, 4'd2, 16'hBBBB);
        applyStimulus(1'b1, 4'd2, 16'hAAAA, 1'b0, '0, '0);
        idle(3);

        applyStimulus(1'b1, 4'd1, 16'h0001, 1'b0, '0, '0);
        applyStimulus(1'b1, 4'd15, 16'h1234, 1'b1, 4'd15, 16'hAEAE);
        idle(3);

        applyStimulus(1'b1, 4'd6, 16'h6666, 1'b1, 4'd8, 16'h8888);
        resetPulse();
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                resetPulse();
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    ra = AW'($urandom_range(0, 3));
                    rb = AW'($urandom_range(0, 3));
                end else begin
                    ra = AW'($urandom_range(0, NREG - 1));
                    rb = AW'($urandom_range(0, NREG - 1));
                end
                applyStimulus($urandom_range(0, 9) < 7, ra, DW'($urandom),
                              $urandom_range(0, 9) < 7, rb, DW'($urandom));
            end
        end

        idle(4);
        @(negedge clk);
        #2;
        drain_check = 1'b1;
        @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
